// File: rtl/vga_sched_pkg.sv
// Shared types and constants for the VGA test-pattern scheduler.
package vga_sched_pkg;

    localparam int unsigned NUM_PATTERNS = 4;
    localparam int unsigned PAT_W        = 2;

    typedef logic [PAT_W-1:0] pattern_t;

    localparam pattern_t PAT_HBARS = 2'd0;
    localparam pattern_t PAT_VBARS = 2'd1;
    localparam pattern_t PAT_XOR   = 2'd2;
    localparam pattern_t PAT_XNOR  = 2'd3;

    typedef enum logic [1:0] {
        ST_MANUAL,
        ST_MANUAL_PEND,
        ST_AUTO,
        ST_AUTO_PEND
    } sched_state_e;

    // Active-low one-hot status LEDs for a pattern code.
    function automatic logic [NUM_PATTERNS-1:0] led_decode(input pattern_t pat);
        return ~(NUM_PATTERNS'(1) << pat);
    endfunction

endpackage

// File: rtl/vga_pattern_scheduler_if.sv
// Board-switch / button inputs and pattern-mux outputs of the scheduler.
interface vga_pattern_scheduler_if;
    import vga_sched_pkg::*;

    logic                    frame_start;
    logic                    auto_en;
    pattern_t                manual_sel;
    logic                    btn_next;
    pattern_t                pattern_sel;
    logic                    mode_changed;
    logic [NUM_PATTERNS-1:0] leds;

    modport master (
        output frame_start, auto_en, manual_sel, btn_next,
        input  pattern_sel, mode_changed, leds
    );

    modport slave (
        input  frame_start, auto_en, manual_sel, btn_next,
        output pattern_sel, mode_changed, leds
    );
endinterface

// File: rtl/vga_btn_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter and
// a one-cycle pulse on each accepted rising level.
module vga_btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync_q1;
    logic             sync_q2;
    logic             level_q;
    logic             level_prev_q;
    logic [CNT_W-1:0] cnt_q;

    // Level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q1      <= 1'b0;
            sync_q2      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
            press        <= 1'b0;
        end else begin
            sync_q1      <= btn_raw;
            sync_q2      <= sync_q1;
            level_prev_q <= level_q;
            press        <= level_q & ~level_prev_q;
            if (sync_q2 != level_q) begin
                if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_q <= ~level_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/vga_pattern_scheduler.sv
// Frame-synchronous selector of the VGA test pattern: manual switches or
// auto cycling with a skip button, changes applied only at frame_start.
module vga_pattern_scheduler
    import vga_sched_pkg::*;
#(
    parameter int unsigned HOLD_FRAMES     = 120,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                    clock,
    input  logic                    reset,
    vga_pattern_scheduler_if.slave  bus
);

    localparam int unsigned CNT_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    sched_state_e            state_q, state_d;
    pattern_t                pattern_q, pattern_d;
    logic [CNT_W-1:0]        hold_cnt_q, hold_cnt_d;
    logic                    mode_changed_q, mode_changed_d;
    logic [NUM_PATTERNS-1:0] leds_q;
    logic                    press;
    logic                    hold_expired;
    logic                    manual_diff;

    vga_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clock  (clock),
        .reset  (reset),
        .btn_raw(bus.btn_next),
        .press  (press)
    );

    assign hold_expired = (hold_cnt_q == CNT_W'(HOLD_FRAMES - 1));
    assign manual_diff  = (bus.manual_sel != pattern_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_MANUAL;
            pattern_q      <= PAT_HBARS;
            hold_cnt_q     <= '0;
            mode_changed_q <= 1'b0;
            leds_q         <= led_decode(PAT_HBARS);
        end else begin
            state_q        <= state_d;
            pattern_q      <= pattern_d;
            hold_cnt_q     <= hold_cnt_d;
            mode_changed_q <= mode_changed_d;
            leds_q         <= led_decode(pattern_d);
        end
    end

    // Next state; a mode switch always wins over a same-cycle frame_start.
    always_comb begin
        state_d        = state_q;
        pattern_d      = pattern_q;
        hold_cnt_d     = hold_cnt_q;
        mode_changed_d = 1'b0;

        case (state_q)
            ST_MANUAL, ST_MANUAL_PEND: begin
                hold_cnt_d = '0;
                if (bus.auto_en) begin
                    state_d = ST_AUTO;
                end else if (manual_diff) begin
                    if (bus.frame_start) begin
                        pattern_d      = bus.manual_sel;
                        mode_changed_d = 1'b1;
                        state_d        = ST_MANUAL;
                    end else begin
                        state_d = ST_MANUAL_PEND;
                    end
                end else begin
                    state_d = ST_MANUAL;
                end
            end

            ST_AUTO, ST_AUTO_PEND: begin
                if (!bus.auto_en) begin
                    state_d    = ST_MANUAL;
                    hold_cnt_d = '0;
                end else if (bus.frame_start) begin
                    // Pending skip and hold expiry collapse into one advance.
                    if (state_q == ST_AUTO_PEND || hold_expired) begin
                        pattern_d      = pattern_q + PAT_W'(1);
                        hold_cnt_d     = '0;
                        mode_changed_d = 1'b1;
                        state_d        = ST_AUTO;
                    end else begin
                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
                        state_d    = press ? ST_AUTO_PEND : ST_AUTO;
                    end
                end else if (press) begin
                    state_d = ST_AUTO_PEND;
                end
            end

            default: state_d = ST_MANUAL;
        endcase
    end

    assign bus.pattern_sel  = pattern_q;
    assign bus.mode_changed = mode_changed_q;
    assign bus.leds         = leds_q;

endmodule

// File: tb/tb_vga_pattern_scheduler.sv
// Directed bench for vga_pattern_scheduler with HOLD_FRAMES=3, DEBOUNCE_CYCLES=4.
module tb_vga_pattern_scheduler;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   mc_count = 0;
    int   base;

    vga_pattern_scheduler_if bus ();

    vga_pattern_scheduler #(
        .HOLD_FRAMES    (3),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.mode_changed === 1'b1) mc_count++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic frame();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic press_btn();
        bus.btn_next = 1'b1;
        idle(8);
        bus.btn_next = 1'b0;
        idle(10);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.auto_en     = 1'b0;
        bus.manual_sel  = 2'd0;
        bus.btn_next    = 1'b0;

        // Reset values
        idle(3);
        check("rst_pattern", 8'(bus.pattern_sel), 8'd0);
        check("rst_leds", 8'(bus.leds), 8'h0E);
        check("rst_mc", 8'(bus.mode_changed), 8'd0);
        reset = 1'b0;
        idle(2);
        base = mc_count;
        frame();
        idle(3);
        frame();
        idle(2);
        check("idle_pattern", 8'(bus.pattern_sel), 8'd0);
        check("idle_pulses", 8'(mc_count - base), 8'd0);

        // Manual change waits for frame_start
        base = mc_count;
        bus.manual_sel = 2'd2;
        idle(4);
        check("man_hold", 8'(bus.pattern_sel), 8'd0);
        frame();
        check("man_apply", 8'(bus.pattern_sel), 8'd2);
        check("man_pulse", 8'(bus.mode_changed), 8'd1);
        check("man_leds", 8'(bus.leds), 8'h0B);
        tick();
        check("man_pulse_end", 8'(bus.mode_changed), 8'd0);
        check("man_pulse_cnt", 8'(mc_count - base), 8'd1);

        // 2 -> 1 -> 2 before frame_start: no change
        base = mc_count;
        bus.manual_sel = 2'd1;
        idle(2);
        bus.manual_sel = 2'd2;
        idle(2);
        frame();
        idle(2);
        check("man_revert", 8'(bus.pattern_sel), 8'd2);
        check("man_revert_cnt", 8'(mc_count - base), 8'd0);

        // Back to pattern 0 then auto cycling
        bus.manual_sel = 2'd0;
        idle(2);
        frame();
        idle(2);
        check("man_zero", 8'(bus.pattern_sel), 8'd0);
        bus.auto_en = 1'b1;
        idle(2);
        base = mc_count;
        for (int i = 1; i <= 12; i++) begin
            frame();
            check($sformatf("auto_f%0d", i), 8'(bus.pattern_sel), 8'((i / 3) % 4));
            idle(3);
        end
        check("auto_pulse_cnt", 8'(mc_count - base), 8'd4);

        // Button skip mid-hold clears the counter
        frame();
        idle(2);
        press_btn();
        check("btn_wait", 8'(bus.pattern_sel), 8'd0);
        base = mc_count;
        frame();
        check("btn_adv", 8'(bus.pattern_sel), 8'd1);
        idle(2);
        frame(); idle(2);
        frame(); idle(2);
        check("btn_cnt_clr", 8'(bus.pattern_sel), 8'd1);
        frame();
        check("btn_next_auto", 8'(bus.pattern_sel), 8'd2);
        idle(2);
        check("btn_pulse_cnt", 8'(mc_count - base), 8'd2);

        // Bounce of 2-cycle glitches is rejected
        base = mc_count;
        for (int i = 0; i < 4; i++) begin
            bus.btn_next = 1'b1;
            idle(2);
            bus.btn_next = 1'b0;
            idle(2);
        end
        idle(10);
        frame(); idle(2);
        check("bounce_f1", 8'(bus.pattern_sel), 8'd2);
        frame(); idle(2);
        check("bounce_f2", 8'(bus.pattern_sel), 8'd2);
        check("bounce_pulses", 8'(mc_count - base), 8'd0);

        // Counter at 2 with press pending: exactly one advance
        press_btn();
        base = mc_count;
        frame();
        check("coin_adv", 8'(bus.pattern_sel), 8'd3);
        idle(3);
        check("coin_pulses", 8'(mc_count - base), 8'd1);
        frame(); idle(2);
        check("coin_cnt_clr", 8'(bus.pattern_sel), 8'd3);

        // AUTO_PEND discarded by switching to manual at the current pattern
        press_btn();
        base = mc_count;
        bus.manual_sel = 2'd3;
        bus.auto_en    = 1'b0;
        idle(2);
        frame();
        idle(2);
        check("mode_drop", 8'(bus.pattern_sel), 8'd3);
        check("mode_drop_cnt", 8'(mc_count - base), 8'd0);

        // Reset while AUTO_PEND, with a coincident frame_start
        bus.auto_en = 1'b1;
        idle(2);
        press_btn();
        base = mc_count;
        reset = 1'b1;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        check("rst_pend_pattern", 8'(bus.pattern_sel), 8'd0);
        check("rst_pend_mc", 8'(bus.mode_changed), 8'd0);
        check("rst_pend_leds", 8'(bus.leds), 8'h0E);
        tick();
        bus.auto_en = 1'b0;
        reset = 1'b0;
        idle(3);
        check("rst_pend_cnt", 8'(mc_count - base), 8'd0);
        check("rst_after", 8'(bus.pattern_sel), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
